// File: rtl/sev_seg_capture.sv
`default_nettype none
// ============================================================================
// Module      : sev_seg_capture
// Description : Reads back the hex values shown on a two-digit multiplexed
//               common-anode seven-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
module sev_seg_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_in,
    input  logic [1:0] an_in,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic       valid0,
    output logic       valid1,
    output logic       update,
    output logic       err
);

    localparam logic [7:0] c_sat  = 8'(STABLE_CYCLES);
    localparam logic [7:0] c_last = 8'(STABLE_CYCLES - 1);
    localparam logic [6:0] c_blank = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HELD   = 2'd2
    } state_t;

    logic [8:0] r_sync1;
    logic [8:0] r_sync2;
    logic [8:0] r_prev;
    logic [7:0] r_count;
    state_t     r_state;
    state_t     w_state_next;
    logic       w_change;
    logic       w_an_ok;
    logic       w_capture;
    logic       w_legal;
    logic       w_blank;
    logic [3:0] w_value;

    // Sample layout is {an[1:0], seg[6:0]}; all-ones means no anode and blank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_prev  <= '1;
        end else begin
            r_sync1 <= {an_in, seg_in};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_change = (r_sync2 != r_prev);
    assign w_an_ok  = r_sync2[8] ^ r_sync2[7];
    assign w_blank  = (r_sync2[6:0] == c_blank);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_change) begin
            r_count <= '0;
        end else if (r_count != c_sat) begin
            r_count <= r_count + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        if (!w_an_ok) begin
            w_state_next = S_IDLE;
        end else if (w_change) begin
            w_state_next = S_SETTLE;
        end else begin
            case (r_state)
                S_IDLE:   w_state_next = S_SETTLE;
                S_SETTLE: begin
                    // The sample was equal for one more cycle than the counter shows.
                    if (r_count == c_last) begin
                        w_capture    = 1'b1;
                        w_state_next = S_HELD;
                    end
                end
                S_HELD:   w_state_next = S_HELD;
                default:  w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_legal = 1'b1;
        w_value = 4'h0;
        case (r_sync2[6:0])
            7'b1000000: w_value = 4'h0;
            7'b1111001: w_value = 4'h1;
            7'b0100100: w_value = 4'h2;
            7'b0110000: w_value = 4'h3;
            7'b0011001: w_value = 4'h4;
            7'b0010010: w_value = 4'h5;
            7'b0000010: w_value = 4'h6;
            7'b1111000: w_value = 4'h7;
            7'b0000000: w_value = 4'h8;
            7'b0011000: w_value = 4'h9;
            7'b0100000: w_value = 4'hA;
            7'b0000011: w_value = 4'hB;
            7'b1000110: w_value = 4'hC;
            7'b0100001: w_value = 4'hD;
            7'b0000110: w_value = 4'hE;
            7'b0001110: w_value = 4'hF;
            default:    w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit0 <= '0;
            digit1 <= '0;
            valid0 <= 1'b0;
            valid1 <= 1'b0;
            update <= 1'b0;
            err    <= 1'b0;
        end else begin
            update <= w_capture;
            err    <= w_capture & ~w_legal & ~w_blank;
            // an[0] low selects digit0; otherwise an[1] is the low one.
            if (w_capture) begin
                if (!r_sync2[7]) begin
                    valid0 <= w_legal;
                    if (w_legal) begin
                        digit0 <= w_value;
                    end
                end else begin
                    valid1 <= w_legal;
                    if (w_legal) begin
                        digit1 <= w_value;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sev_seg_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_sev_seg_capture
// Description : Self-checking bench for sev_seg_capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sev_seg_capture;

    localparam int S = 4;

    logic       clk;
    logic       reset;
    logic [6:0] seg_in;
    logic [1:0] an_in;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic       valid0;
    logic       valid1;
    logic       update;
    logic       err;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    sev_seg_capture #(.STABLE_CYCLES(S)) dut (
        .clk    (clk),
        .reset  (reset),
        .seg_in (seg_in),
        .an_in  (an_in),
        .digit0 (digit0),
        .digit1 (digit1),
        .valid0 (valid0),
        .valid1 (valid1),
        .update (update),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] pat [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0100000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic int decode(input logic [6:0] s);
        for (int i = 0; i < 16; i++) begin
            if (pat[i] == s) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: hist[k] holds the raw input seen k+1 edges ago.
    // A capture happens when the value that has just emerged from the
    // synchronizer has been identical for exactly S+1 consecutive raw samples.
    logic [8:0] hist [0:S+2];
    logic [3:0] m_d0, m_d1;
    logic       m_v0, m_v1, m_upd, m_err;

    function automatic bit cap_now();
        bit run = (hist[1][8] != hist[1][7]) && (hist[S+2] != hist[1]);
        for (int k = 2; k <= S + 1; k++) begin
            if (hist[k] != hist[1]) run = 1'b0;
        end
        return run;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < S + 3; k++) hist[k] <= 9'h1FF;
            m_d0 <= 4'h0; m_d1 <= 4'h0;
            m_v0 <= 1'b0; m_v1 <= 1'b0;
            m_upd <= 1'b0; m_err <= 1'b0;
        end else begin
            m_upd <= cap_now();
            m_err <= cap_now() && decode(hist[1][6:0]) < 0 && hist[1][6:0] != 7'h7F;
            if (cap_now()) begin
                if (!hist[1][7]) begin
                    m_v0 <= (decode(hist[1][6:0]) >= 0);
                    if (decode(hist[1][6:0]) >= 0) m_d0 <= 4'(decode(hist[1][6:0]));
                end else begin
                    m_v1 <= (decode(hist[1][6:0]) >= 0);
                    if (decode(hist[1][6:0]) >= 0) m_d1 <= 4'(decode(hist[1][6:0]));
                end
            end
            for (int k = S + 2; k > 0; k--) hist[k] <= hist[k-1];
            hist[0] <= {an_in, seg_in};
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model", {digit0, digit1, valid0, valid1, update, err},
                  {m_d0, m_d1, m_v0, m_v1, m_upd, m_err});
        end
    end

    typedef struct {
        logic [1:0] an;
        logic [6:0] seg;
        int         dwell;
        logic [3:0] d0;
        logic       v0;
        logic [3:0] d1;
        logic       v1;
        int         upd;
        int         er;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int uc, ec, r;

        tbl[0]  = '{2'b01, 7'b0001110, 12, 4'h3, 1'b1, 4'hF, 1'b1, 1, 0};
        tbl[1]  = '{2'b10, 7'b0010010, 12, 4'h5, 1'b1, 4'hF, 1'b1, 1, 0};
        tbl[2]  = '{2'b01, 7'b0001110, 12, 4'h5, 1'b1, 4'hF, 1'b1, 1, 0};
        tbl[3]  = '{2'b10, 7'b1010101, 12, 4'h5, 1'b0, 4'hF, 1'b1, 1, 1};
        tbl[4]  = '{2'b10, 7'b1111111, 12, 4'h5, 1'b0, 4'hF, 1'b1, 1, 0};
        tbl[5]  = '{2'b11, 7'b0000000, 50, 4'h5, 1'b0, 4'hF, 1'b1, 0, 0};
        tbl[6]  = '{2'b00, 7'b1111001, 50, 4'h5, 1'b0, 4'hF, 1'b1, 0, 0};
        tbl[7]  = '{2'b01, 7'b0000011, 12, 4'h5, 1'b0, 4'hB, 1'b1, 1, 0};
        tbl[8]  = '{2'b10, 7'b0100001, 12, 4'hD, 1'b1, 4'hB, 1'b1, 1, 0};
        tbl[9]  = '{2'b01, 7'b1111111, 12, 4'hD, 1'b1, 4'hB, 1'b0, 1, 0};
        tbl[10] = '{2'b10, 7'b1000110, 12, 4'hC, 1'b1, 4'hB, 1'b0, 1, 0};
        tbl[11] = '{2'b01, 7'b0110000, 12, 4'hC, 1'b1, 4'h3, 1'b1, 1, 0};

        reset  = 1'b1;
        an_in  = 2'b11;
        seg_in = 7'b1111111;
        repeat (3) @(negedge clk);
        check("reset_outputs", {digit0, digit1, valid0, valid1, update, err}, 32'h0);

        // Exact capture latency: inputs present before edge 0, capture at edge 2+S.
        reset  = 1'b0;
        chk_en = 1'b1;
        an_in  = 2'b10;
        seg_in = 7'b0110000;
        for (int e = 0; e < 8; e++) begin
            @(negedge clk);
            check($sformatf("lat_upd_e%0d", e), update, (e == 2 + S));
            check($sformatf("lat_d0_e%0d", e), digit0, (e >= 2 + S) ? 4'h3 : 4'h0);
            check($sformatf("lat_v0_e%0d", e), valid0, (e >= 2 + S));
            check($sformatf("lat_err_e%0d", e), err, 1'b0);
            check($sformatf("lat_d1v1_e%0d", e), {digit1, valid1}, 5'h0);
        end

        for (int i = 0; i < 12; i++) begin
            an_in  = tbl[i].an;
            seg_in = tbl[i].seg;
            uc = 0;
            ec = 0;
            repeat (tbl[i].dwell) begin
                @(negedge clk);
                if (update) uc++;
                if (err) ec++;
            end
            check($sformatf("tbl%0d_digit0", i), digit0, tbl[i].d0);
            check($sformatf("tbl%0d_valid0", i), valid0, tbl[i].v0);
            check($sformatf("tbl%0d_digit1", i), digit1, tbl[i].d1);
            check($sformatf("tbl%0d_valid1", i), valid1, tbl[i].v1);
            check($sformatf("tbl%0d_updates", i), uc, tbl[i].upd);
            check($sformatf("tbl%0d_errs", i), ec, tbl[i].er);
        end

        // Glitch of S-1 cycles during a digit0 hold of 5.
        an_in  = 2'b10;
        seg_in = 7'b0010010;
        repeat (12) @(negedge clk);
        seg_in = 7'b0000000;
        uc = 0;
        for (int c = 0; c < 2 + S + S - 1; c++) begin
            if (c == S - 1) seg_in = 7'b0010010;
            @(negedge clk);
            if (update) uc++;
            check($sformatf("glitch_d0_c%0d", c), digit0, 4'h5);
        end
        check("glitch_no_update", uc, 0);
        uc = 0;
        repeat (4) begin
            @(negedge clk);
            if (update) uc++;
        end
        check("glitch_recapture", uc, 1);
        check("glitch_final_d0", {digit0, valid0}, {4'h5, 1'b1});

        // Reset two cycles into SETTLE.
        seg_in = 7'b0100100;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_reset", {digit0, digit1, valid0, valid1, update, err}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int e = 0; e < 8; e++) begin
            @(negedge clk);
            check($sformatf("rst_upd_e%0d", e), update, (e == 2 + S));
            check($sformatf("rst_d0_e%0d", e), {digit0, valid0},
                  (e >= 2 + S) ? {4'h2, 1'b1} : 5'h0);
        end

        // Randomized episodes checked every cycle against the model.
        for (int ep = 0; ep < 300; ep++) begin
            r = int'($urandom_range(0, 9));
            an_in = (r < 4) ? 2'b10 : (r < 8) ? 2'b01 : (r == 8) ? 2'b00 : 2'b11;
            r = int'($urandom_range(0, 19));
            if (r < 12) seg_in = pat[$urandom_range(0, 15)];
            else if (r < 15) seg_in = 7'b1111111;
            else seg_in = 7'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            repeat ($urandom_range(1, 12)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sev_seg_capture.md
# sev_seg_capture

Monitors the segment and anode lines of the two-digit multiplexed common-anode seven-segment display and recovers the hex value shown on each digit. It is the decode direction of the board's hex-to-segment encoder, and it sits beside the display driver as a self-check and readback block. Inputs are asynchronous to `clk`; the block synchronizes them, waits for the pattern to settle, and captures one value per stable display episode.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: number of consecutive identical synchronized samples required before a capture. Legal range is 2..255.

Ports:
- `clk` input, 1: system clock.
- `reset` input, 1: asynchronous, active-high reset.
- `seg_in` input, 7: segment lines, active-low. Bit 0 = a through bit 6 = g.
- `an_in` input, 2: anode enables, active-low. Bit 0 selects digit0; bit 1 selects digit1.
- `digit0` output, 4: last legal value captured for digit0.
- `digit1` output, 4: last legal value captured for digit1.
- `valid0` output, 1: `digit0` holds a legal captured value.
- `valid1` output, 1: `digit1` holds a legal captured value.
- `update` output, 1: one-cycle pulse on every capture, whether legal, blank or illegal.
- `err` output, 1: one-cycle pulse when an illegal pattern is captured.

## Operation
- **Synchronizer:** 2-flop synchronizer on all 9 input bits (`seg_in` and `an_in`). Both stages reset to all-ones, which means no anode and blank.
- **Stability counter:**
  - An 8-bit counter compares the synchronized 9-bit sample with the previous sample.
  - If they are equal, the counter increments, saturating at `STABLE_CYCLES`.
  - Otherwise it clears to 0.
- **State machine:**
  - IDLE: the synchronized `an_in` is not exactly one low. This covers 11 (no digit) and 00 (ghost). No capture occurs. The block moves to SETTLE when exactly one anode bit is low.
  - SETTLE: counting. On reaching the stability requirement, the block captures once and moves to HELD. Any change in the sample clears the counter and restarts SETTLE, or moves to IDLE if the anode is no longer valid.
  - HELD: no further capture while the sample is unchanged. Any change returns the block to SETTLE or IDLE as above.
- **Decode (legal patterns, `seg_in[6:0]` → value):**
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3
  - 0011001→4, 0010010→5, 0000010→6, 1111000→7
  - 0000000→8, 0011000→9, 0100000→A, 0000011→b
  - 1000110→C, 0100001→d, 0000110→E, 0001110→F
- **Capture action (applies to the selected digit only):**
  - Legal pattern: `digitN` takes the value, `validN` is set to 1, and `update` pulses.
  - Blank pattern 1111111: `digitN` holds, `validN` clears, and `update` pulses. `err` does not pulse.
  - Any other pattern: `digitN` holds, `validN` clears, and both `update` and `err` pulse.
- **Unselected digit:** its registers never change during the other digit's capture.

## Timing
- **Reset values:** `digit0` and `digit1` are 0, `valid0` and `valid1` are 0, `update` and `err` are 0. The state is IDLE, the counter is 0, and the synchronizers are all-ones.
- **Capture latency:** when inputs are set up before rising edge 0 and then held, the capture registers update at edge `2+STABLE_CYCLES`. With the default of 4, that is edge 6.
- **Pulses:** `update` and `err` are high for exactly the one cycle following the capture edge.
- **Glitch rejection:** any input change lasting fewer than `STABLE_CYCLES` synchronized cycles produces no capture and no pulse.
- **Simultaneous anode and segment change:** treated as a single sample change. The counter clears and only the new pattern can be captured.
- **Reset mid-SETTLE:** asserting `reset` clears everything immediately and asynchronously. After deassertion, a fresh full latency applies.
- **Repeated patterns:** exactly one capture per HELD episode. A repeated identical pattern after an intervening change captures again.

## Test plan
- Reset, then drive `an_in`=10 with `seg_in`=0110000 held → `digit0`=3 and `valid0`=1 at edge 6. `update` pulses for 1 cycle, `err` stays 0, and `digit1`/`valid1` stay 0.
- Alternate `an_in`=10/01 every 20 cycles with patterns for 5 and F → `digit0`=5 and `digit1`=F. There is one `update` per anode dwell and none while held.
- Apply a 3-cycle glitch to 0000000 during a digit0 hold of 0010010, with `STABLE_CYCLES`=4 → no `update` pulse, and `digit0` remains 5.
- `an_in`=10 with `seg_in`=1010101 → `err` and `update` pulse, `valid0`=0, and `digit0` holds its prior value. Then `seg_in`=1111111 → `update` pulses, `err` stays 0, and `valid0` stays 0.
- `an_in`=00 or 11 with a legal pattern held for 50 cycles → no `update` and all outputs unchanged.
- Assert `reset` 2 cycles into SETTLE, with an edge-6 capture pending → no capture. After release, the first capture occurs 6 edges after release.
